// File: rtl/cfu_ram_slave.sv
// Wishbone-classic CFU RAM slave with configurable wait states
// and a host preload port that only writes while the bus is idle.
module cfu_ram_slave #(
  parameter int          DEPTH       = 1024,
  parameter logic [29:0] BASE_ADR    = 30'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [29:0]              cfu_ram_adr,
  input  logic [31:0]              cfu_ram_dat_mosi,
  input  logic [3:0]               cfu_ram_sel,
  input  logic                     cfu_ram_cyc,
  input  logic                     cfu_ram_stb,
  input  logic                     cfu_ram_we,
  input  logic [2:0]               cfu_ram_cti,
  input  logic [1:0]               cfu_ram_bte,
  output logic [31:0]              cfu_ram_dat_miso,
  output logic                     cfu_ram_ack,
  output logic                     cfu_ram_err,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [$clog2(DEPTH)-1:0] ld_adr,
  input  logic [31:0]              ld_dat
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        hit_q;
  logic        ack_q, err_q;
  logic [31:0] miso_q;

  logic [31:0] mem_q [DEPTH];

  logic          req, idle, cap, go_resp;
  logic [29:0]   acc_adr;
  logic [31:0]   acc_dat;
  logic [3:0]    acc_sel;
  logic          acc_we, acc_hit;
  logic [30:0]   off;
  logic          hit_now;
  logic [AW-1:0] acc_idx;
  logic          ld_fire, wr_fire;

  assign req  = cfu_ram_cyc & cfu_ram_stb;
  assign idle = (state_q == S_IDLE);

  // In IDLE a zero-wait or miss response uses the live request
  assign acc_adr = idle ? cfu_ram_adr      : adr_q;
  assign acc_dat = idle ? cfu_ram_dat_mosi : dat_q;
  assign acc_sel = idle ? cfu_ram_sel      : sel_q;
  assign acc_we  = idle ? cfu_ram_we       : we_q;

  assign off     = {1'b0, acc_adr} - {1'b0, BASE_ADR};
  assign hit_now = off < 31'(DEPTH);
  assign acc_idx = off[AW-1:0];
  assign acc_hit = idle ? hit_now : hit_q;

  assign ld_ready = reset & idle & ~req;
  assign ld_fire  = ld_valid & ld_ready;
  assign wr_fire  = go_resp & acc_hit & acc_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    go_resp = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          cap   = 1'b1;
          cnt_d = 4'(WAIT_STATES);
          if (WAIT_STATES > 0 && hit_now) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!cfu_ram_cyc) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          go_resp = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= 30'd0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      miso_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        adr_q <= cfu_ram_adr;
        dat_q <= cfu_ram_dat_mosi;
        sel_q <= cfu_ram_sel;
        we_q  <= cfu_ram_we;
        hit_q <= hit_now;
      end
      ack_q  <= go_resp & acc_hit;
      err_q  <= go_resp & ~acc_hit;
      miso_q <= (go_resp & acc_hit & ~acc_we)
              ? mem_q[acc_idx] : 32'd0;
    end
  end

  // Contents survive reset; preload and bus write never coincide
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      mem_q[ld_adr] <= ld_dat;
    end else if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_sel[b]) begin
          mem_q[acc_idx][8*b +: 8] <= acc_dat[8*b +: 8];
        end
      end
    end
  end

  assign cfu_ram_ack      = ack_q;
  assign cfu_ram_err      = err_q;
  assign cfu_ram_dat_miso = miso_q;

  logic unused_ok;
  assign unused_ok = ^{cfu_ram_cti, cfu_ram_bte};

endmodule

// File: tb/tb_cfu_ram_slave.sv
// Randomized bench for cfu_ram_slave: two instances (1 and 3 wait
// states) checked against an array model of the word memory.
module tb_cfu_ram_slave;

  localparam int          DEPTH = 16;
  localparam logic [29:0] BASE  = 30'h100;
  localparam int          WS0   = 1;
  localparam int          WS1   = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [29:0] adr   [2];
  logic [31:0] mosi  [2];
  logic [3:0]  sel   [2];
  logic [2:0]  cti   [2];
  logic [1:0]  bte   [2];
  logic [3:0]  ldadr [2];
  logic [31:0] lddat [2];
  logic [1:0]  cyc, stb, we, ldv;
  wire  [31:0] miso  [2];
  wire  [1:0]  ack, err, ldr;

  logic [31:0] model [2][DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  cfu_ram_slave #(
    .DEPTH(DEPTH), .BASE_ADR(BASE), .WAIT_STATES(WS0)
  ) u0 (
    .clk(clk), .reset(reset),
    .cfu_ram_adr(adr[0]), .cfu_ram_dat_mosi(mosi[0]),
    .cfu_ram_sel(sel[0]), .cfu_ram_cyc(cyc[0]),
    .cfu_ram_stb(stb[0]), .cfu_ram_we(we[0]),
    .cfu_ram_cti(cti[0]), .cfu_ram_bte(bte[0]),
    .cfu_ram_dat_miso(miso[0]), .cfu_ram_ack(ack[0]),
    .cfu_ram_err(err[0]), .ld_valid(ldv[0]),
    .ld_ready(ldr[0]), .ld_adr(ldadr[0]), .ld_dat(lddat[0])
  );

  cfu_ram_slave #(
    .DEPTH(DEPTH), .BASE_ADR(BASE), .WAIT_STATES(WS1)
  ) u1 (
    .clk(clk), .reset(reset),
    .cfu_ram_adr(adr[1]), .cfu_ram_dat_mosi(mosi[1]),
    .cfu_ram_sel(sel[1]), .cfu_ram_cyc(cyc[1]),
    .cfu_ram_stb(stb[1]), .cfu_ram_we(we[1]),
    .cfu_ram_cti(cti[1]), .cfu_ram_bte(bte[1]),
    .cfu_ram_dat_miso(miso[1]), .cfu_ram_ack(ack[1]),
    .cfu_ram_err(err[1]), .ld_valid(ldv[1]),
    .ld_ready(ldr[1]), .ld_adr(ldadr[1]), .ld_dat(lddat[1])
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ws(int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  // Called at a negedge; returns at a negedge with the bus idle
  task automatic xfer(int k, logic [29:0] a, logic [31:0] d,
                      logic [3:0] s, logic w,
                      output logic [31:0] rd);
    int lat;
    int off;
    bit hit;
    logic [31:0] exp_d;
    off = int'(a) - int'(BASE);
    hit = (off >= 0) && (off < DEPTH);
    adr[k] = a; mosi[k] = d; sel[k] = s; we[k] = w;
    cti[k] = 3'($urandom); bte[k] = 2'($urandom);
    cyc[k] = 1'b1; stb[k] = 1'b1;
    #1 check("ldrdy_req", 32'(ldr[k]), 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(ack[k] | err[k]) && lat < 40);
    exp_d = 32'h0;
    if (hit && !w) exp_d = model[k][off];
    rd = miso[k];
    check("latency", lat, hit ? ws(k) + 1 : 1);
    check("ack", 32'(ack[k]), 32'(hit));
    check("err", 32'(err[k]), 32'(!hit));
    check("miso", miso[k], exp_d);
    if (hit && w)
      for (int b = 0; b < 4; b++)
        if (s[b]) model[k][off][8*b +: 8] = d[8*b +: 8];
    cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
    @(negedge clk);
    check("resp_post", {30'd0, err[k], ack[k]}, 0);
    check("miso_post", miso[k], 0);
  endtask

  task automatic preload(int k, int idx, logic [31:0] d);
    int n;
    n = 0;
    ldv[k] = 1'b1; ldadr[k] = 4'(idx); lddat[k] = d;
    #1;
    while (!ldr[k] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("ld_wait", 32'(n < 20), 1);
    @(negedge clk);
    ldv[k] = 1'b0;
    model[k][idx] = d;
  endtask

  task automatic watch_quiet(int k, int ncyc, string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (ack[k] | err[k]) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [29:0] a;
    int k;
    for (int i = 0; i < 2; i++) begin
      adr[i] = '0; mosi[i] = '0; sel[i] = '0;
      cti[i] = '0; bte[i] = '0; ldadr[i] = '0; lddat[i] = '0;
    end
    cyc = '0; stb = '0; we = '0; ldv = '0;

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_ack", 32'(ack[i]), 0);
      check("rst_err", 32'(err[i]), 0);
      check("rst_miso", miso[i], 0);
      check("rst_ldrdy", 32'(ldr[i]), 0);
    end
    reset = 1'b1;
    // First edge after release: miss just past the top
    xfer(0, BASE + 30'(DEPTH), 32'h0, 4'hf, 1'b0, rd);
    xfer(1, BASE - 30'd1, 32'h0, 4'hf, 1'b0, rd);

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++)
        preload(i, j, $urandom);

    preload(0, 5, 32'h1122_3344);
    xfer(0, BASE + 30'd5, 32'h0, 4'hf, 1'b0, rd);
    check("rd_preload", rd, 32'h1122_3344);
    xfer(0, BASE + 30'd5, 32'hAABB_CCDD, 4'b0101, 1'b1, rd);
    xfer(0, BASE + 30'd5, 32'h0, 4'hf, 1'b0, rd);
    check("rd_masked", rd, 32'h11BB_33DD);
    xfer(0, BASE + 30'(DEPTH), 32'hDEAD_BEEF, 4'hf, 1'b1, rd);
    xfer(0, BASE + 30'(DEPTH - 1), 32'h0, 4'hf, 1'b0, rd);
    xfer(0, BASE + 30'd5, 32'hFFFF_FFFF, 4'h0, 1'b1, rd);
    xfer(0, BASE + 30'd5, 32'h0, 4'hf, 1'b0, rd);
    check("rd_sel0", rd, 32'h11BB_33DD);
    xfer(0, BASE, 32'h0, 4'hf, 1'b0, rd);

    // Preload contending with a bus write to the same word
    ldv[0] = 1'b1; ldadr[0] = 4'd7; lddat[0] = 32'hCAFE_0007;
    xfer(0, BASE + 30'd7, 32'h0BAD_0BAD, 4'hf, 1'b1, rd);
    #1 check("ldrdy_idle", 32'(ldr[0]), 1);
    @(negedge clk);
    ldv[0] = 1'b0;
    model[0][7] = 32'hCAFE_0007;
    xfer(0, BASE + 30'd7, 32'h0, 4'hf, 1'b0, rd);
    check("rd_contend", rd, 32'hCAFE_0007);

    // Abort by dropping cyc in WAIT
    adr[1] = BASE + 30'd3; mosi[1] = 32'h5555_AAAA;
    sel[1] = 4'hf; we[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
    watch_quiet(1, 2, "abort_early");
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    watch_quiet(1, 6, "abort_quiet");
    xfer(1, BASE + 30'd3, 32'h0, 4'hf, 1'b0, rd);

    // Reset pulse mid-WAIT
    adr[1] = BASE + 30'd9; mosi[1] = 32'h7777_8888;
    sel[1] = 4'hf; we[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
    watch_quiet(1, 2, "rstw_early");
    reset = 1'b0;
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    #1 check("rstw_ldrdy", 32'(ldr[1]), 0);
    check("rstw_ack", {30'd0, err[1], ack[1]}, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rstw_rel_ldrdy", 32'(ldr[1]), 1);
    watch_quiet(1, 6, "rstw_quiet");
    xfer(1, BASE + 30'd9, 32'h0, 4'hf, 1'b0, rd);

    for (int n = 0; n < 120; n++) begin
      k = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        preload(k, int'($urandom_range(0, DEPTH - 1)), $urandom);
      end else begin
        a = BASE - 30'd2 + 30'($urandom_range(0, DEPTH + 3));
        xfer(k, a, $urandom, 4'($urandom), 1'($urandom), rd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
